bcd_pair_sequencer: RTL and testbench
=====================================

// Module: bcd_pair_sequencer
// PURPOSE
//   Multicycle controller that converts two unsigned binary operands to 2-digit BCD.
//   Uses one shared shift-add-3 (double-dabble) datapath, time-multiplexed: operand A first, then operand B.
//   Drop-in sequential replacement for the dual combinational converter pair in the display path.
//   start/ready/done handshake; packed 16-bit BCD result held until the next conversion completes.
// PARAMETERS
//   NUM_W  6  operand width in bits; legal range 1..6, so the value always fits in 2 BCD digits.
//   Iterations per operand = NUM_W; total conversion = 2*NUM_W cycles.
// PORTS
//   clk      in   1      single clock; all state changes on the rising edge
//   rst      in   1      asynchronous, active-high reset
//   start    in   1      conversion request; sampled only when ready=1
//   IN_A     in   NUM_W  operand A (low result byte)
//   IN_B     in   NUM_W  operand B (high result byte)
//   ready    out  1      block can accept start this cycle
//   busy     out  1      conversion in progress (CONV_A or CONV_B)
//   done     out  1      one-cycle pulse: BCD_OUT updated this cycle
//   BCD_OUT  out  16     {tensB, unitsB, tensA, unitsA}, one 4-bit digit each; registered
// BEHAVIOUR
//   Reset (asynchronous, takes effect immediately, including mid-operation):
//     state=IDLE; busy=0; done=0; BCD_OUT=16'h0000; internal shift registers and counter cleared.
//     ready=1 once rst deasserts. rst wins over a simultaneous start.
//   FSM states:
//     IDLE: ready=1. start=1 -> capture IN_A/IN_B into internal regs, load shifter with A, cnt=0 -> CONV_A.
//     CONV_A: one iteration per cycle.
//       Each 4-bit digit >=5 gets +3, then {digits, operand} shifts left by 1.
//       After NUM_W iterations: latch A digits into a holding reg, load shifter with B, cnt=0 -> CONV_B.
//     CONV_B: same iteration. After NUM_W iterations: BCD_OUT <= {B digits, A digits}; done=1 -> DONE.
//     DONE: done=1 for exactly this cycle -> IDLE (see CONFIGURATION for start handling).
//   Latency:
//     start sampled at edge k -> BCD_OUT valid and done=1 in the cycle after edge k+2*NUM_W (12 for NUM_W=6).
//     BCD_OUT is stable from that edge until the next done.
//   Operands are captured at start; IN_A/IN_B changes during CONV_A/CONV_B do not affect the result.
//   start while busy=1 is ignored, never queued.
//   busy=1 only in CONV_A/CONV_B; ready=1 only in IDLE (plus DONE when the macro is defined).
//   Counter width is ceil(log2(NUM_W+1)); it wraps only via explicit reload, never free-running.
//   Unused upper digit bits are always 0; tens digit <=6 for NUM_W=6 (max 63 -> 8'h63).
// CONFIGURATION
//   BCD_SEQ_BACK2BACK_EN
//     Defined:
//       DONE also drives ready=1; start in DONE captures new operands and goes straight to CONV_A.
//       Sustained throughput is one result per 2*NUM_W+1 cycles; done is still a 1-cycle pulse per result.
//     Undefined:
//       ready=0 in DONE; start in DONE is ignored; DONE always -> IDLE.
//       Minimum spacing between results is 2*NUM_W+2 cycles.
// TESTING
//   1. rst=1 while in CONV_A (cycle 3 after start):
//      -> same cycle busy=0, done=0, BCD_OUT=16'h0000; after release, start with A=5,B=7 -> 16'h0705.
//   2. A=63, B=0, start 1 cycle:
//      -> done exactly 12 cycles later, BCD_OUT=16'h0063; busy high for 12 cycles.
//   3. A=9, B=10 -> BCD_OUT=16'h1009.
//      During busy, set A=0,B=0 and pulse start -> result unchanged, no extra done.
//   4. Back-to-back, start asserted in the DONE cycle with A=1,B=2:
//      -> macro defined: next done 13 cycles after the first, BCD_OUT=16'h0201.
//      -> undefined: start ignored, ready returns in IDLE, no second done.
//   5. Sweep all A,B in 0..63 (NUM_W=6) against a reference model:
//      -> every BCD_OUT matches {B/10,B%10,A/10,A%10}; one done per start.
//   6. NUM_W=4, A=15, B=9 -> done 8 cycles after start, BCD_OUT=16'h0915.

Source files
------------

// File: rtl/bcd_pair_sequencer.sv
// Sequential binary-to-BCD converter for two operands sharing one double-dabble datapath.
// Optional macro BCD_SEQ_BACK2BACK_EN: accept a new start in the DONE cycle for back-to-back results.
module bcd_pair_sequencer #(
   parameter int NUM_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NUM_W-1:0] IN_A,
   input  logic [NUM_W-1:0] IN_B,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [15:0]      BCD_OUT
);

   localparam int CW = $clog2(NUM_W + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NUM_W - 1);

   typedef enum logic [1:0] {IDLE, CONV_A, CONV_B, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [7:0]       dig_q, dig_d;
   logic [NUM_W-1:0] op_q, op_d;
   logic [NUM_W-1:0] opb_q, opb_d;
   logic [7:0]       dig_a_q, dig_a_d;
   logic [15:0]      bcd_q, bcd_d;

   logic [7:0]         dig_adj;
   logic [NUM_W+7:0]   shift_word;
   logic [7:0]         dig_step;
   logic [NUM_W-1:0]   op_step;
   logic               load;

   // Add-3 correction on each digit before the shared left shift.
   for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      assign dig_adj[gi*4 +: 4] = (dig_q[gi*4 +: 4] >= 4'd5) ? dig_q[gi*4 +: 4] + 4'd3
                                                              : dig_q[gi*4 +: 4];
   end

   assign shift_word = {dig_adj, op_q} << 1;
   assign dig_step   = shift_word[NUM_W+7:NUM_W];
   assign op_step    = shift_word[NUM_W-1:0];

`ifdef BCD_SEQ_BACK2BACK_EN
   assign ready = (state_q == IDLE) || (state_q == DONE);
`else
   assign ready = (state_q == IDLE);
`endif
   assign busy    = (state_q == CONV_A) || (state_q == CONV_B);
   assign done    = (state_q == DONE);
   assign BCD_OUT = bcd_q;
   assign load    = start && ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      op_d    = op_q;
      opb_d   = opb_q;
      dig_a_d = dig_a_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE: ;
         CONV_A: begin
            dig_d = dig_step;
            op_d  = op_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               dig_a_d = dig_step;
               dig_d   = 8'h00;
               op_d    = opb_q;
               cnt_d   = '0;
               state_d = CONV_B;
            end
         end
         CONV_B: begin
            dig_d = dig_step;
            op_d  = op_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               bcd_d   = {dig_step, dig_a_q};
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A new request overrides the default IDLE/DONE transitions.
      if (load) begin
         op_d    = IN_A;
         opb_d   = IN_B;
         dig_d   = 8'h00;
         cnt_d   = '0;
         state_d = CONV_A;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dig_q   <= 8'h00;
         op_q    <= '0;
         opb_q   <= '0;
         dig_a_q <= 8'h00;
         bcd_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         op_q    <= op_d;
         opb_q   <= opb_d;
         dig_a_q <= dig_a_d;
         bcd_q   <= bcd_d;
      end
   end

endmodule

// File: tb/tb_bcd_pair_sequencer.sv
// Self-checking bench for bcd_pair_sequencer: NUM_W=6 and NUM_W=4 instances against a decimal reference model.
module tb_bcd_pair_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_v [2];
   logic [5:0]  in_a_v  [2];
   logic [5:0]  in_b_v  [2];
   logic        ready_v [2];
   logic        busy_v  [2];
   logic        done_v  [2];
   logic [15:0] bcd_v   [2];

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt [2];

   always #5 clk = ~clk;

   bcd_pair_sequencer #(.NUM_W(6)) dut6 (
      .clk(clk), .rst(rst), .start(start_v[0]),
      .IN_A(in_a_v[0]), .IN_B(in_b_v[0]),
      .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .BCD_OUT(bcd_v[0])
   );

   bcd_pair_sequencer #(.NUM_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start_v[1]),
      .IN_A(in_a_v[1][3:0]), .IN_B(in_b_v[1][3:0]),
      .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .BCD_OUT(bcd_v[1])
   );

   always @(negedge clk) begin
      if (done_v[0]) done_cnt[0] = done_cnt[0] + 1;
      if (done_v[1]) done_cnt[1] = done_cnt[1] + 1;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits of each operand, B in the high byte.
   function automatic int exp_bcd(input int a, input int b);
      return ((b / 10) << 12) | ((b % 10) << 8) | ((a / 10) << 4) | (a % 10);
   endfunction

`ifdef BCD_SEQ_BACK2BACK_EN
   localparam int READY_IN_DONE = 1;
`else
   localparam int READY_IN_DONE = 0;
`endif

   // One conversion; returns at the negedge where done is seen.
   task automatic run_conv(input int s, input int a, input int b, input int nw,
                           input bit junk, input string tag);
      int lat = -1;
      int busy_n = 0;
      int rdy_n = 0;
      int rdy_done = -1;
      @(negedge clk);
      in_a_v[s]  = 6'(a);
      in_b_v[s]  = 6'(b);
      start_v[s] = 1'b1;
      for (int j = 1; j <= 60; j++) begin
         @(negedge clk);
         start_v[s] = 1'b0;
         if (done_v[s]) begin
            lat = j - 1;
            rdy_done = int'(ready_v[s]);
            break;
         end
         if (busy_v[s]) busy_n++;
         if (ready_v[s]) rdy_n++;
         if (junk) begin
            in_a_v[s]  = 6'($urandom);
            in_b_v[s]  = 6'($urandom);
            start_v[s] = 1'($urandom_range(0, 1));
         end
      end
      start_v[s] = 1'b0;
      check_eq({tag, "_latency"}, lat, 2 * nw);
      check_eq({tag, "_busy_cycles"}, busy_n, 2 * nw);
      check_eq({tag, "_ready_while_busy"}, rdy_n, 0);
      check_eq({tag, "_ready_in_done"}, rdy_done, READY_IN_DONE);
      check_eq({tag, "_bcd"}, int'(bcd_v[s]), exp_bcd(a, b));
      $display("%s: NUM_W=%0d A=%0d B=%0d BCD_OUT=%04h latency=%0d", tag, nw, a, b, bcd_v[s], lat);
   endtask

   initial begin
      int d0;
      int lat2;
      done_cnt[0] = 0;
      done_cnt[1] = 0;
      for (int s = 0; s < 2; s++) begin
         start_v[s] = 1'b0;
         in_a_v[s]  = '0;
         in_b_v[s]  = '0;
      end

      // Power-on reset
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", int'(busy_v[0]), 0);
      check_eq("rst_done", int'(done_v[0]), 0);
      check_eq("rst_bcd", int'(bcd_v[0]), 0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_ready6", int'(ready_v[0]), 1);
      check_eq("rst_ready4", int'(ready_v[1]), 1);

      // Full-scale A, zero B
      run_conv(0, 63, 0, 6, 1'b0, "max_a");

      // Asynchronous reset in the middle of CONV_A
      @(negedge clk);
      in_a_v[0] = 6'd33; in_b_v[0] = 6'd44; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("pre_rst_busy", int'(busy_v[0]), 1);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_busy", int'(busy_v[0]), 0);
      check_eq("mid_rst_done", int'(done_v[0]), 0);
      check_eq("mid_rst_bcd", int'(bcd_v[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("post_rst_ready", int'(ready_v[0]), 1);
      run_conv(0, 5, 7, 6, 1'b0, "after_rst");

      // Operand capture and ignored start while busy
      @(negedge clk);
      in_a_v[0] = 6'd9; in_b_v[0] = 6'd10; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      d0 = done_cnt[0];
      in_a_v[0] = 6'd0; in_b_v[0] = 6'd0;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      lat2 = -1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (done_v[0]) begin lat2 = j; break; end
      end
      check_eq("capture_done_seen", int'(lat2 > 0), 1);
      check_eq("capture_bcd", int'(bcd_v[0]), 16'h1009);
      repeat (20) @(negedge clk);
      check_eq("capture_done_count", done_cnt[0] - d0, 1);
      check_eq("capture_bcd_held", int'(bcd_v[0]), 16'h1009);
      $display("capture: A=9 B=10 with busy-time changes BCD_OUT=%04h", bcd_v[0]);

      // Start asserted in the DONE cycle
      run_conv(0, 3, 4, 6, 1'b0, "b2b_first");
      in_a_v[0] = 6'd1; in_b_v[0] = 6'd2; start_v[0] = 1'b1;
      lat2 = -1;
      for (int j = 1; j <= 30; j++) begin
         @(negedge clk);
         start_v[0] = 1'b0;
         if (done_v[0]) begin lat2 = j; break; end
      end
`ifdef BCD_SEQ_BACK2BACK_EN
      check_eq("b2b_spacing", lat2, 13);
      check_eq("b2b_bcd", int'(bcd_v[0]), 16'h0201);
`else
      check_eq("b2b_no_second_done", lat2, -1);
      check_eq("b2b_bcd_held", int'(bcd_v[0]), 16'h0403);
      check_eq("b2b_ready_idle", int'(ready_v[0]), 1);
`endif
      $display("b2b: second start in DONE, gap=%0d BCD_OUT=%04h", lat2, bcd_v[0]);

      // NUM_W=4 instance
      run_conv(1, 15, 9, 4, 1'b0, "w4_dir");
      for (int i = 0; i < 20; i++)
         run_conv(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 4, 1'b1, "w4_rand");

      // Exhaustive operand sweep with random input noise while busy
      d0 = done_cnt[0];
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 64; b++) begin
            run_conv(0, a, b, 6, 1'b1, "sweep");
            repeat ($urandom_range(0, 1)) @(negedge clk);
         end
      end
      @(negedge clk);
      check_eq("sweep_done_count", done_cnt[0] - d0, 4096);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
